// File: rtl/if_prefetch_unit.sv
// if_prefetch_unit: MIPS instruction-fetch stage.
// Holds the fetch PC and a loadable instruction memory, and feeds a small
// prefetch queue. The queue head goes to decode through a valid/ready
// handshake. The unit also handles branch/jump redirects, which flush the
// queue, debug single-stepping, and stopping on a HALT word.
module if_prefetch_unit #(
    parameter int unsigned          BITS_SIZE  = 32,
    parameter int unsigned          MEM_WORDS  = 64,
    parameter int unsigned          FIFO_DEPTH = 4,
    parameter logic [BITS_SIZE-1:0] HALT_WORD  = 32'hFFFFFFFF
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_debug_mode,
    input  logic                          i_step,
    input  logic                          i_load_en,
    input  logic [BITS_SIZE-1:0]          i_load_addr,
    input  logic [BITS_SIZE-1:0]          i_load_data,
    input  logic                          i_redirect,
    input  logic [BITS_SIZE-1:0]          i_redirect_pc,
    input  logic                          i_ready,
    output logic                          o_valid,
    output logic [BITS_SIZE-1:0]          o_instruction,
    output logic [BITS_SIZE-1:0]          o_pc,
    output logic [BITS_SIZE-1:0]          o_pc4,
    output logic [BITS_SIZE-1:0]          o_pc8,
    output logic                          o_halted,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

    localparam int unsigned   AW      = $clog2(MEM_WORDS);
    localparam int unsigned   PW      = $clog2(FIFO_DEPTH);
    localparam int unsigned   CW      = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic [BITS_SIZE-1:0] r_mem     [MEM_WORDS];
    logic [BITS_SIZE-1:0] r_q_instr [FIFO_DEPTH];
    logic [BITS_SIZE-1:0] r_q_pc    [FIFO_DEPTH];
    logic [PW-1:0]        r_head;
    logic [PW-1:0]        r_tail;
    logic [CW-1:0]        r_count;
    logic [BITS_SIZE-1:0] r_fetch_pc;
    logic                 r_halted;
    logic [BITS_SIZE-1:0] r_last_pc;

    logic                 w_enable;
    logic                 w_valid;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_fetch_ok;
    logic                 w_load_ok;
    logic [BITS_SIZE-1:0] w_fetch_word;
    logic [BITS_SIZE-1:0] w_head_pc;
    logic                 w_unused;

    // The byte-offset bits of the load address do not select a word.
    assign w_unused = ^i_load_addr[1:0];

    // Handshake and priority decode, plus the combinational memory read.
    always_comb begin
        w_enable     = ~i_debug_mode | i_step;
        w_valid      = (r_count != '0);
        w_pop        = w_enable & ~i_redirect & w_valid & i_ready;
        w_push       = w_enable & ~i_redirect & ~r_halted & ~i_load_en &
                       ((r_count < DEPTH_C) | w_pop);
        w_fetch_ok   = (r_fetch_pc[BITS_SIZE-1:AW+2] == '0);
        w_load_ok    = (i_load_addr[BITS_SIZE-1:AW+2] == '0);
        w_fetch_word = w_fetch_ok ? r_mem[r_fetch_pc[AW+1:2]] : '0;
        w_head_pc    = w_valid ? r_q_pc[r_head] : r_last_pc;
    end

    // Instruction memory write. Memory has no reset, so a loaded program
    // survives a core reset. A load that coincides with reset is dropped.
    always_ff @(posedge i_clk) begin
        if (i_reset && i_load_en && w_load_ok)
            r_mem[i_load_addr[AW+1:2]] <= i_load_data;
    end

    // Queue storage. It needs no reset because o_valid gates its use.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_q_instr[r_tail] <= w_fetch_word;
            r_q_pc[r_tail]    <= r_fetch_pc;
        end
    end

    // Control state: fetch PC, pointers, occupancy, halt flag and the held PC.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_fetch_pc <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_halted   <= 1'b0;
            r_last_pc  <= '0;
        end else if (w_enable) begin
            // Keep the last PC shown so that o_pc holds while the queue is empty.
            r_last_pc <= w_head_pc;
            if (i_redirect) begin
                r_head     <= '0;
                r_tail     <= '0;
                r_count    <= '0;
                r_fetch_pc <= i_redirect_pc;
                r_halted   <= 1'b0;
            end else begin
                if (w_pop)
                    r_head <= r_head + PW'(1);
                if (w_push) begin
                    r_tail     <= r_tail + PW'(1);
                    r_fetch_pc <= r_fetch_pc + BITS_SIZE'(4);
                    if (w_fetch_word == HALT_WORD)
                        r_halted <= 1'b1;
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CW'(1);
                    2'b01:   r_count <= r_count - CW'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    assign o_valid       = w_valid;
    assign o_instruction = w_valid ? r_q_instr[r_head] : '0;
    assign o_pc          = w_head_pc;
    assign o_pc4         = w_head_pc + BITS_SIZE'(4);
    assign o_pc8         = w_head_pc + BITS_SIZE'(8);
    assign o_halted      = r_halted;
    assign o_fifo_count  = r_count;

endmodule

// File: tb/tb_if_prefetch_unit.sv
// tb_if_prefetch_unit: bench for if_prefetch_unit.
// It runs directed vector tables and hand-written corner sequences, then a
// randomised run. All results are checked against a queue-based reference.
module tb_if_prefetch_unit;

    localparam int BW = 32;
    localparam int MW = 64;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          rst_n, dbg, step, ld_en, redir, rdy;
    logic [BW-1:0] ld_addr, ld_data, rpc;
    logic          valid, halted;
    logic [BW-1:0] instr, pc, pc4, pc8;
    logic [2:0]    cnt;

    always #5 clk = ~clk;

    if_prefetch_unit #(
        .BITS_SIZE (BW),
        .MEM_WORDS (MW),
        .FIFO_DEPTH(FD),
        .HALT_WORD (32'hFFFFFFFF)
    ) dut (
        .i_clk        (clk),
        .i_reset      (rst_n),
        .i_debug_mode (dbg),
        .i_step       (step),
        .i_load_en    (ld_en),
        .i_load_addr  (ld_addr),
        .i_load_data  (ld_data),
        .i_redirect   (redir),
        .i_redirect_pc(rpc),
        .i_ready      (rdy),
        .o_valid      (valid),
        .o_instruction(instr),
        .o_pc         (pc),
        .o_pc4        (pc4),
        .o_pc8        (pc8),
        .o_halted     (halted),
        .o_fifo_count (cnt)
    );

    // Reference model: a queue of {pc, instruction} entries and a flat word array.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_mem[MW];
    logic [31:0] m_fpc, m_last;
    bit          m_halt;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] m_pc();
        return (q.size() != 0) ? q[0].pc : m_last;
    endfunction

    function automatic void model_reset();
        q.delete();
        m_fpc  = 0;
        m_last = 0;
        m_halt = 0;
    endfunction

    function automatic void model_step();
        logic [31:0] word;
        bit          pop, push;
        word = (m_fpc[31:8] == 0) ? m_mem[m_fpc[7:2]] : 32'h0;
        if (!dbg || step) begin
            m_last = m_pc();
            if (redir) begin
                q.delete();
                m_fpc  = rpc;
                m_halt = 0;
            end else begin
                pop  = (q.size() > 0) && rdy;
                push = !m_halt && !ld_en && ((q.size() < FD) || pop);
                if (pop) void'(q.pop_front());
                if (push) begin
                    q.push_back('{m_fpc, word});
                    m_fpc = m_fpc + 4;
                    if (word == 32'hFFFFFFFF) m_halt = 1;
                end
            end
        end
        if (ld_en && ld_addr[31:8] == 0) m_mem[ld_addr[7:2]] = ld_data;
    endfunction

    task automatic check_model(input string tag);
        logic [31:0] ep;
        ep = m_pc();
        chk({tag, ".valid"}, {31'b0, valid}, {31'b0, q.size() != 0});
        chk({tag, ".instr"}, instr, (q.size() != 0) ? q[0].ins : 32'h0);
        chk({tag, ".pc"}, pc, ep);
        chk({tag, ".pc4"}, pc4, ep + 4);
        chk({tag, ".pc8"}, pc8, ep + 8);
        chk({tag, ".halted"}, {31'b0, halted}, {31'b0, m_halt});
        chk({tag, ".count"}, {29'b0, cnt}, q.size());
    endtask

    // Drive one cycle's inputs, advance the model and sample 1 ns after the edge.
    task automatic apply(input bit d, input bit s, input bit l, input logic [31:0] a,
                         input logic [31:0] dat, input bit r, input logic [31:0] rp,
                         input bit rd);
        dbg = d; step = s; ld_en = l; ld_addr = a; ld_data = dat;
        redir = r; rpc = rp; rdy = rd;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, ".valid"}, {31'b0, valid}, 32'h0);
        chk({tag, ".instr"}, instr, 32'h0);
        chk({tag, ".pc"}, pc, 32'h0);
        chk({tag, ".pc4"}, pc4, 32'h4);
        chk({tag, ".pc8"}, pc8, 32'h8);
        chk({tag, ".halted"}, {31'b0, halted}, 32'h0);
        chk({tag, ".count"}, {29'b0, cnt}, 32'h0);
    endtask

    task automatic do_reset();
        dbg = 0; step = 0; ld_en = 0; redir = 0; rdy = 0;
        rst_n = 1'b0;
        #1;
        check_reset_vals("reset");
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit          ld;
        logic [31:0] addr;
        logic [31:0] data;
        bit          rd;
        logic [31:0] rp;
        bit          ry;
        bit          e_valid;
        logic [31:0] e_ins;
        logic [31:0] e_pc;
        int          e_cnt;
        bit          e_halt;
    } vec_t;

    vec_t tbl[16];

    initial begin
        tbl[0]  = '{0, 0, 0,            0, 0,     1, 1, 32'h20010005, 32'h0,  1, 0};
        tbl[1]  = '{0, 0, 0,            0, 0,     1, 1, 32'h20020007, 32'h4,  1, 0};
        tbl[2]  = '{0, 0, 0,            0, 0,     1, 1, 32'hFFFFFFFF, 32'h8,  1, 1};
        tbl[3]  = '{0, 0, 0,            0, 0,     1, 0, 32'h0,        32'h8,  0, 1};
        tbl[4]  = '{0, 0, 0,            0, 0,     1, 0, 32'h0,        32'h8,  0, 1};
        tbl[5]  = '{0, 0, 0,            1, 0,     0, 0, 32'h0,        32'h8,  0, 0};
        tbl[6]  = '{0, 0, 0,            0, 0,     0, 1, 32'h20010005, 32'h0,  1, 0};
        tbl[7]  = '{1, 32'h400, 32'hDEADBEEF, 0, 0, 0, 1, 32'h20010005, 32'h0, 1, 0};
        tbl[8]  = '{1, 32'h10, 32'h12345678,  0, 0, 0, 1, 32'h20010005, 32'h0, 1, 0};
        tbl[9]  = '{0, 0, 0,            0, 0,     1, 1, 32'h20020007, 32'h4,  1, 0};
        tbl[10] = '{0, 0, 0,            0, 0,     1, 1, 32'hFFFFFFFF, 32'h8,  1, 1};
        tbl[11] = '{0, 0, 0,            0, 0,     1, 0, 32'h0,        32'h8,  0, 1};
        tbl[12] = '{0, 0, 0,            1, 0,     0, 0, 32'h0,        32'h8,  0, 0};
        tbl[13] = '{0, 0, 0,            0, 0,     0, 1, 32'h20010005, 32'h0,  1, 0};
        tbl[14] = '{0, 0, 0,            1, 32'h10, 0, 0, 32'h0,       32'h0,  0, 0};
        tbl[15] = '{0, 0, 0,            0, 0,     0, 1, 32'h12345678, 32'h10, 1, 0};

        rst_n = 0; dbg = 0; step = 0; ld_en = 0; ld_addr = 0; ld_data = 0;
        redir = 0; rpc = 0; rdy = 0;
        for (int i = 0; i < MW; i++) m_mem[i] = 0;
        model_reset();
        #1;
        check_reset_vals("init");
        @(posedge clk);
        #1;
        rst_n = 1;

        // Clear memory, then load the three-word program.
        for (int i = 0; i < MW; i++) apply(0, 0, 1, 32'(i * 4), 32'h0, 0, 0, 0);
        apply(0, 0, 1, 32'h0, 32'h20010005, 0, 0, 0);
        apply(0, 0, 1, 32'h4, 32'h20020007, 0, 0, 0);
        apply(0, 0, 1, 32'h8, 32'hFFFFFFFF, 0, 0, 0);
        check_model("preload");

        // Directed table: program run, halt, redirect, loads.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            apply(0, 0, tbl[i].ld, tbl[i].addr, tbl[i].data, tbl[i].rd, tbl[i].rp, tbl[i].ry);
            chk($sformatf("tbl%0d.valid", i), {31'b0, valid}, {31'b0, tbl[i].e_valid});
            chk($sformatf("tbl%0d.instr", i), instr, tbl[i].e_ins);
            chk($sformatf("tbl%0d.pc", i), pc, tbl[i].e_pc);
            chk($sformatf("tbl%0d.pc8", i), pc8, tbl[i].e_pc + 8);
            chk($sformatf("tbl%0d.count", i), {29'b0, cnt}, 32'(tbl[i].e_cnt));
            chk($sformatf("tbl%0d.halted", i), {31'b0, halted}, {31'b0, tbl[i].e_halt});
        end

        // Backpressure with a HALT-free program.
        apply(0, 0, 1, 32'h8, 32'h0, 0, 0, 0);
        do_reset();
        for (int i = 0; i < 6; i++) begin
            apply(0, 0, 0, 0, 0, 0, 0, 0);
            chk($sformatf("bp%0d.count", i), {29'b0, cnt}, (i < 3) ? 32'(i + 1) : 32'd4);
            chk($sformatf("bp%0d.pc", i), pc, 32'h0);
        end
        apply(0, 0, 0, 0, 0, 0, 0, 1);
        chk("bp_pop.count", {29'b0, cnt}, 32'd4);
        chk("bp_pop.pc", pc, 32'h4);
        check_model("bp");

        // Redirect with three entries queued.
        do_reset();
        for (int i = 0; i < 3; i++) apply(0, 0, 0, 0, 0, 0, 0, 0);
        chk("rd_pre.count", {29'b0, cnt}, 32'd3);
        apply(0, 0, 0, 0, 0, 1, 32'h40, 0);
        chk("rd.valid", {31'b0, valid}, 32'h0);
        chk("rd.count", {29'b0, cnt}, 32'h0);
        apply(0, 0, 0, 0, 0, 0, 0, 0);
        chk("rd_next.valid", {31'b0, valid}, 32'h1);
        chk("rd_next.pc", pc, 32'h40);
        chk("rd_next.pc4", pc4, 32'h44);
        chk("rd_next.pc8", pc8, 32'h48);

        // Debug mode: state frozen without a step; a load still lands.
        for (int i = 0; i < 10; i++) begin
            apply(1, 0, 0, 0, 0, 0, 0, 1);
            chk($sformatf("dbg%0d.count", i), {29'b0, cnt}, 32'd1);
            chk($sformatf("dbg%0d.pc", i), pc, 32'h40);
        end
        apply(1, 0, 1, 32'h48, 32'hCAFE0001, 0, 0, 1);
        chk("dbg_ld.count", {29'b0, cnt}, 32'd1);
        apply(1, 1, 0, 0, 0, 0, 0, 0);
        chk("step0.count", {29'b0, cnt}, 32'd2);
        chk("step0.pc", pc, 32'h40);
        apply(1, 1, 0, 0, 0, 0, 0, 1);
        chk("step1.count", {29'b0, cnt}, 32'd2);
        chk("step1.pc", pc, 32'h44);
        apply(0, 0, 0, 0, 0, 0, 0, 1);
        chk("step2.instr", instr, 32'hCAFE0001);
        check_model("dbg");

        // Asynchronous reset in the middle of a cycle.
        apply(0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("async");
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Randomised run against the model, including PC wrap-around.
        for (int i = 0; i < 500; i++) begin
            logic [31:0] a, d, r;
            a = ($urandom % 4 == 0) ? 32'h400 + $urandom_range(0, 255) : $urandom_range(0, 255);
            d = ($urandom % 5 == 0) ? 32'hFFFFFFFF : $urandom;
            r = ($urandom % 6 == 0) ? 32'hFFFFFFF0 + 4 * $urandom_range(0, 3)
                                    : $urandom_range(0, 255);
            apply($urandom % 4 == 0, $urandom % 2 == 0, $urandom % 12 == 0, a, d,
                  $urandom % 10 == 0, r, $urandom % 3 != 0);
            check_model($sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/if_prefetch_unit.md
Name: if_prefetch_unit

Overview:
- Next-generation instruction-fetch stage for the MIPS pipeline.
- Combines a parametrised PC, a loadable instruction memory and a FIFO_DEPTH-entry prefetch queue.
- Decouples fetch from decode with a valid/ready handshake, supports branch/jump redirect with queue flush, debug single-step gating, and a HALT-word stop.
- Sits between the debug loader / EX-stage redirect logic and the IF/ID pipeline register.

Parameters:
- BITS_SIZE, 32: data, address and PC width.
- MEM_WORDS, 64: instruction memory depth in 32-bit words (power of 2).
- FIFO_DEPTH, 4: prefetch queue entries (power of 2, >=2).
- HALT_WORD, 32'hFFFFFFFF: instruction encoding that stops fetching.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  reset, asynchronous, active-low.
- i_debug_mode  in  1  1 = single-step mode.
- i_step  in  1  step pulse; advances the unit one cycle in debug mode.
- i_load_en  in  1  write i_load_data into instruction memory.
- i_load_addr  in  BITS_SIZE  byte address of the loaded word.
- i_load_data  in  BITS_SIZE  instruction word to load.
- i_redirect  in  1  branch/jump taken; flush the queue and redirect.
- i_redirect_pc  in  BITS_SIZE  new fetch PC.
- i_ready  in  1  decode accepts the head entry; 0 = hazard stall.
- o_valid  out  1  head entry valid.
- o_instruction  out  BITS_SIZE  head instruction.
- o_pc  out  BITS_SIZE  PC of head instruction.
- o_pc4  out  BITS_SIZE  o_pc+4.
- o_pc8  out  BITS_SIZE  o_pc+8.
- o_halted  out  1  HALT_WORD fetched; fetch stopped.
- o_fifo_count  out  $clog2(FIFO_DEPTH)+1  occupied entries.

Behaviour:
- One clock domain. The interface is fixed: one clock, reset asynchronous and active-low.
- Reset (i_reset=0, asynchronous): fetch_pc=0, queue empty, o_valid=0, o_instruction=0, o_pc=0, o_pc4=4, o_pc8=8, o_halted=0, o_fifo_count=0.
- Instruction memory contents are retained across reset, so a program can be loaded and then the core reset.
- enable = ~i_debug_mode | i_step. When enable=0, all state holds; loads are the only exception.
- Load:
  - i_load_en=1 writes mem[i_load_addr[log2(MEM_WORDS)+1:2]] at the clock edge, independent of enable.
  - Out-of-range addresses (upper bits nonzero) are ignored.
  - Fetch push is suppressed in any cycle with i_load_en=1.
- Memory read is combinational at fetch_pc word index. Out-of-range or misaligned low bits: address bits [1:0] are ignored; out-of-range reads return 0 (NOP).
- Priority per enabled cycle:
  - 1. i_redirect: queue cleared (count=0), fetch_pc<=i_redirect_pc, o_halted<=0. No push and no pop this cycle.
  - 2. Otherwise, pop when o_valid & i_ready.
  - 3. Push when ~o_halted & ~i_load_en & (count<FIFO_DEPTH | pop). A push writes {fetch_pc, mem word} at the tail and sets fetch_pc<=fetch_pc+4.
  - 4. If the pushed word == HALT_WORD, o_halted<=1. The HALT entry itself is still queued and delivered.
- Simultaneous push+pop: allowed when full or non-empty; count unchanged.
- Push into an empty queue: the entry appears at the head the next cycle (1-cycle fetch latency).
- Head outputs are registered queue contents. When o_valid=0, o_instruction=0 and o_pc holds its last value.
- Arithmetic: all PC additions are modulo 2^BITS_SIZE. fetch_pc wraps from 2^BITS_SIZE-4 to 0.
- o_valid = (count!=0). Pointers are log2(FIFO_DEPTH) bits wide and wrap naturally.
- Reset mid-operation (asynchronous) discards queued entries immediately. A load in progress at reset is discarded if reset is active at the edge.

Test Plan:
- Load words 0x20010005, 0x20020007, 0xFFFFFFFF at byte addresses 0,4,8; release reset; hold i_ready=1.
  - Required: o_valid from cycle 2, sequence pc 0,4,8 with those instructions.
  - Required: o_halted=1 after the HALT push; no further entries.
- Hold i_ready=0 with memory of 8 NOP-like words.
  - Required: o_fifo_count rises 1,2,3,4 then stays 4; fetch_pc stops at 16; o_pc stays 0.
  - Then raise i_ready for 1 cycle: count stays 4, o_pc=4.
- With 3 entries queued (pc 0,4,8), pulse i_redirect with i_redirect_pc=0x40.
  - Required: next cycle o_valid=0, count=0; the following cycle o_pc=0x40, o_pc4=0x44, o_pc8=0x48.
- Set i_debug_mode=1 with no i_step for 10 cycles.
  - Required: count and o_pc unchanged.
  - Then each single i_step pulse adds exactly one entry (i_ready=0), or pops one and pushes one (i_ready=1).
- With o_halted=1, apply i_redirect to 0x0.
  - Required: o_halted clears; fetching resumes from pc 0.
- Assert i_load_en continuously during normal run.
  - Required: no pushes while asserted; a load to address 0x400 (out of range, MEM_WORDS=64) leaves memory unchanged.
- Assert i_reset low mid-stream.
  - Required: all outputs take their reset values immediately, without waiting for a clock edge.
